// File: rtl/dcache_wb_if.sv
// dcache_wb_if: CPU request/response and line-granular memory bus of dcache_wb.
// slave  = cache side: takes req_*, mem_req_ready, mem_resp_valid, mem_rdata;
//          drives req_ready, resp_*, mem_req_*, mem_wdata.
// master = CPU/memory side: the mirror image.
interface dcache_wb_if #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                            req_valid, req_write, req_ready, resp_valid;
  logic [ADDR_WIDTH-1:0]           req_addr, mem_req_addr;
  logic [WORD_SIZE-1:0]            req_wdata, resp_rdata;
  logic                            mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid;
  logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate data cache with a line-granular memory port.
// Ports: clk, rst (async active-high), bus (dcache_wb_if.slave: CPU req/resp + memory req/resp).
// Macro DCACHE_STATS_EN adds hit_count/miss_count/wb_count outputs (32-bit, wrapping).
module dcache_wb #(
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 16,
  parameter int LINES      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  dcache_wb_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = ADDR_WIDTH - IDX - OFF;
  localparam int LB  = WORD_SIZE * LINE_WORDS;
  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND} state_t;
  state_t                state, state_n;
  logic [LB-1:0]         data_q [LINES];
  logic [TAG-1:0]        tag_q [LINES];
  logic [LINES-1:0]      valid_q, dirty_q;
  logic                  lat_write, hit, accept, fill;
  logic [ADDR_WIDTH-1:0] lat_addr, cur_addr;
  logic [WORD_SIZE-1:0]  lat_wdata;
  logic [TAG-1:0]        tg;
  logic [IDX-1:0]        idx;
  logic [OFF-1:0]        off;
  logic [LB-1:0]         line, fill_line;
  int                    sel;
  // Outside IDLE the latched miss address drives the lookup so the line stays put.
  assign cur_addr = state == IDLE ? bus.req_addr : lat_addr;
  assign tg = cur_addr[ADDR_WIDTH-1 -: TAG];
  assign idx = cur_addr[OFF +: IDX];
  assign off = cur_addr[OFF-1:0];
  // Word 0 sits at the MSB end of a line.
  assign sel = (LINE_WORDS - 1 - int'(off)) * WORD_SIZE;
  assign line = data_q[idx];
  assign hit = valid_q[idx] && tag_q[idx] == tg;
  assign bus.req_ready = state == IDLE && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  assign fill = state == REFILL_WAIT && bus.mem_resp_valid;
  assign bus.mem_req_valid = state == WRITEBACK || state == REFILL_REQ;
  assign bus.mem_req_write = state == WRITEBACK;
  assign bus.mem_req_addr = state == WRITEBACK ? {tag_q[idx], idx, {OFF{1'b0}}} :
                            state == REFILL_REQ ? {tg, idx, {OFF{1'b0}}} : '0;
  assign bus.mem_wdata = state == WRITEBACK ? line : '0;
  always_comb begin
    fill_line = bus.mem_rdata;
    if (lat_write) fill_line[sel +: WORD_SIZE] = lat_wdata;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:        if (accept && !hit) state_n = valid_q[idx] && dirty_q[idx] ? WRITEBACK : REFILL_REQ;
      WRITEBACK:   if (bus.mem_req_ready) state_n = REFILL_REQ;
      REFILL_REQ:  if (bus.mem_req_ready) state_n = REFILL_WAIT;
      REFILL_WAIT: if (bus.mem_resp_valid) state_n = RESPOND;
      default:     state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      state <= state_n;
      bus.resp_valid <= (accept && hit) || fill;
      if (accept && hit) bus.resp_rdata <= bus.req_write ? bus.req_wdata : line[sel +: WORD_SIZE];
      if (accept && hit && bus.req_write) dirty_q[idx] <= 1'b1;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= lat_write;
        bus.resp_rdata <= fill_line[sel +: WORD_SIZE];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept && !hit) begin
      lat_write <= bus.req_write;
      lat_addr <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end
    if (accept && hit && bus.req_write) data_q[idx][sel +: WORD_SIZE] <= bus.req_wdata;
    if (fill) begin
      data_q[idx] <= fill_line;
      tag_q[idx] <= tg;
    end
  end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count <= '0;
      miss_count <= '0;
      wb_count <= '0;
    end else begin
      hit_count <= hit_count + 32'(accept && hit);
      miss_count <= miss_count + 32'(accept && !hit);
      wb_count <= wb_count + 32'(state == WRITEBACK && bus.mem_req_ready);
    end
  end
`endif
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed + random checks of dcache_wb against a flat-memory reference model.
module tb_dcache_wb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  dcache_wb_if bus ();
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;
`endif
  dcache_wb dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count),
    .wb_count(wb_count)
`endif
  );
  int nvec = 0, nerr = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] arch [logic [31:0]];
  bit          vm [1024];
  bit          dm [1024];
  logic [17:0] tm [1024];
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] arch_rd(logic [31:0] a);
    return arch.exists(a) ? arch[a] : mem_rd(a);
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 1024; i++) begin
      vm[i] = 1'b0;
      dm[i] = 1'b0;
    end
    arch.delete();
`ifdef DCACHE_STATS_EN
    exp_hit = 0;
    exp_miss = 0;
    exp_wb = 0;
`endif
  endtask
  task automatic do_req(bit wr, logic [31:0] a, logic [31:0] wd, int d, int r);
    int          idx = int'(a[13:4]);
    logic [17:0] tg = a[31:14];
    bit          hit = vm[idx] && tm[idx] == tg;
    bit          wb = !hit && vm[idx] && dm[idx];
    int          exp_lat = hit ? 1 : wb ? 4 + 2 * d + r : 3 + d + r;
    logic [31:0] exp_rd = wr ? wd : arch_rd(a);
    logic [31:0] wb_base = {tm[idx], a[13:4], 4'h0};
    logic [31:0] rd_base = {a[31:4], 4'h0};
    int          cyc = 0, hs = 0, wait_n = 0, rwait = 0, tries = 0;
    bit          pend = 0, got = 0;
    logic [31:0] held_addr;
    logic        held_wr;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr = a;
    bus.req_wdata = wd;
    while (!bus.req_ready && tries < 4) begin
      @(negedge clk);
      tries++;
    end
    chk("req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (bus.resp_valid) begin
        got = 1'b1;
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("resp_rdata", 64'(bus.resp_rdata), 64'(exp_rd));
      end else if (bus.mem_req_valid) begin
        if (wait_n == 0) begin
          held_addr = bus.mem_req_addr;
          held_wr = bus.mem_req_write;
          chk("mem_req_write", 64'(held_wr), 64'(hs == 0 && wb));
          chk("mem_req_addr", 64'(held_addr), 64'(hs == 0 && wb ? wb_base : rd_base));
        end else begin
          chk("hold_addr", 64'(bus.mem_req_addr), 64'(held_addr));
          chk("hold_write", 64'(bus.mem_req_write), 64'(held_wr));
        end
        if (wait_n < d) wait_n++;
        else begin
          bus.mem_req_ready = 1'b1;
          wait_n = 0;
          hs++;
          if (bus.mem_req_write) begin
            for (int i = 0; i < 16; i++) begin
              logic [31:0] w;
              w = bus.mem_wdata[(16 - i) * 32 - 1 -: 32];
              chk("wb_word", 64'(w), 64'(arch_rd(wb_base + 32'(i))));
              mem[wb_base + 32'(i)] = w;
            end
          end else pend = 1'b1;
        end
      end else if (pend) begin
        if (rwait < r) rwait++;
        else begin
          bus.mem_resp_valid = 1'b1;
          pend = 1'b0;
          for (int i = 0; i < 16; i++) bus.mem_rdata[(16 - i) * 32 - 1 -: 32] = mem_rd(rd_base + 32'(i));
        end
      end
    end
    chk("resp_seen", 64'(got), 64'd1);
    if (!hit) begin
      tm[idx] = tg;
      vm[idx] = 1'b1;
      dm[idx] = wr;
    end else if (wr) dm[idx] = 1'b1;
    if (wr) arch[a] = wd;
`ifdef DCACHE_STATS_EN
    if (hit) exp_hit++;
    else exp_miss++;
    if (wb) exp_wb++;
`endif
  endtask
  task automatic start_miss(logic [31:0] a);
    int tries = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr = a;
    while (!bus.req_ready && tries < 4) begin
      @(negedge clk);
      tries++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("miss_req_valid", 64'(bus.mem_req_valid), 64'd1);
  endtask
  initial begin
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata = '0;
    mem[32'h25] = 32'hDEAD_BEEF;
    model_reset();
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_mem_req_write", 64'(bus.mem_req_write), 64'd0);
    chk("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata == '0), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 32'h25, 32'h0, 0, 0);
    do_req(1'b0, 32'h25, 32'h0, 0, 0);
    do_req(1'b1, 32'h25, 32'h1234_5678, 0, 0);
    do_req(1'b0, 32'h4025, 32'h0, 0, 0);
    do_req(1'b0, 32'h4025, 32'h0, 0, 0);
    do_req(1'b0, 32'h8047, 32'h0, 3, 0);
    do_req(1'b1, 32'h30, 32'hCAFE_F00D, 0, 1);
    do_req(1'b0, 32'h30, 32'h0, 0, 0);
    do_req(1'b0, 32'h4030, 32'h0, 1, 2);
    start_miss(32'h9090);
    rst = 1'b1;
    #1;
    chk("rst_drop_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    start_miss(32'h8070);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("refill_wait_idle_bus", 64'(bus.mem_req_valid), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mid_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = '1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    chk("stale_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("stale_req_ready", 64'(bus.req_ready), 64'd1);
    chk("stale_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    do_req(1'b0, 32'h8070, 32'h0, 0, 0);
    do_req(1'b1, 32'h25, 32'h1234_5678, 0, 0);
    do_req(1'b0, 32'h4025, 32'h0, 0, 0);
    do_req(1'b0, 32'h4025, 32'h0, 0, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_count_scn", 64'(hit_count), 64'(exp_hit));
    chk("miss_count_scn", 64'(miss_count), 64'(exp_miss));
    chk("wb_count_scn", 64'(wb_count), 64'(exp_wb));
`endif
    for (int k = 0; k < 300; k++) begin
      a = {16'h0, 2'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 4'($urandom)};
      do_req(1'($urandom), a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end
`ifdef DCACHE_STATS_EN
    chk("hit_count", 64'(hit_count), 64'(exp_hit));
    chk("miss_count", 64'(miss_count), 64'(exp_miss));
    chk("wb_count", 64'(wb_count), 64'(exp_wb));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised direct-mapped, write-back, write-allocate data cache with a single CPU port and a valid/ready line-granular memory port. It is the next-generation data cache: geometry is set by parameters, misses run through an explicit multi-cycle refill/write-back state machine against a memory that answers with variable latency, and the block has an asynchronous reset. It sits between the execute/memory stage and the data memory.

## Interface
- WORD_SIZE, 32: bits per word.
- LINE_WORDS, 16: words per line (power of two, ≥2).
- LINES, 1024: lines in the cache (power of two).
- ADDR_WIDTH, 32: word address width.
- Derived values: OFF = log2(LINE_WORDS); IDX = log2(LINES); TAG = ADDR_WIDTH − IDX − OFF.
- Address split: offset = addr[OFF-1:0]; index = addr[OFF+IDX-1:OFF]; tag = upper bits.
- Line packing: word i occupies bits [(LINE_WORDS−i)·WORD_SIZE−1 −: WORD_SIZE]. Word 0 is at the MSB end, matching data_memory.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  CPU request valid.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  WORD_SIZE  store data.
- req_ready  out  1  cache accepts a request.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  WORD_SIZE  load data, or the stored word for a store.
- mem_req_valid  out  1  memory request valid.
- mem_req_write  out  1  1 = line write-back, 0 = line read.
- mem_req_addr  out  ADDR_WIDTH  line address with offset bits 0.
- mem_wdata  out  WORD_SIZE·LINE_WORDS  write-back line.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  refill line valid.
- mem_rdata  in  WORD_SIZE·LINE_WORDS  refill line.

## Operation
- States: IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND.
- req_ready = 1 only in IDLE with rst low. A request is accepted when req_valid & req_ready.
- IDLE lookup is combinational on req_addr: hit = valid[index] & tag[index] == tag.
- Accepted hit, load: resp_rdata ← word[offset], resp_valid pulses next cycle. State stays IDLE.
- Accepted hit, store: the word is merged at the edge, dirty ← 1, resp_rdata ← req_wdata, resp_valid pulses next cycle.
- Accepted miss: the request is latched. Next state is WRITEBACK if valid & dirty, otherwise REFILL_REQ.
- WRITEBACK drives mem_req_valid = 1, mem_req_write = 1, mem_req_addr = {old tag, index, 0}, mem_wdata = the line. On mem_req_ready it moves to REFILL_REQ.
- REFILL_REQ drives mem_req_valid = 1, mem_req_write = 0, mem_req_addr = {tag, index, 0}. On mem_req_ready it moves to REFILL_WAIT.
- mem_req_* must stay stable while mem_req_valid & !mem_req_ready.
- REFILL_WAIT: on mem_resp_valid the line is installed with tag written and valid ← 1.
  - Load: dirty ← 0.
  - Store: req_wdata is merged into the installed line and dirty ← 1.
  - resp_rdata is registered and the state moves to RESPOND.
- RESPOND: resp_valid = 1 for exactly one cycle, then IDLE.
- mem_resp_valid in any state other than REFILL_WAIT is ignored.
- Reset values: state IDLE; all valid and dirty bits 0; resp_valid 0; resp_rdata 0; mem_req_valid 0; mem_req_write 0; mem_req_addr 0; mem_wdata 0.
- Tag and data arrays are not reset.
- Reset mid-miss: the transaction is abandoned and mem_req_valid drops immediately. Any later mem_resp_valid is ignored. Dirty data is lost by design.

## Timing
- Edge 0 is the accepting edge.
- Hit: resp_valid in cycle 1. A back-to-back request can be accepted in cycle 1.
- Clean miss, memory ready at once, response one cycle after accept: mem_req_valid in cycle 1, mem_resp_valid in cycle 2, resp_valid in cycle 3.
- Dirty miss: add one cycle per write-back handshake, so resp_valid in cycle 4 at minimum.
- Each wait cycle on mem_req_ready or mem_resp_valid adds exactly one cycle.

## Configuration
- DCACHE_STATS_EN defined adds three ports:
  - hit_count  out  32: increments on each accepted hit.
  - miss_count  out  32: increments on each accepted miss.
  - wb_count  out  32: increments on each accepted write-back request.
  - All three reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent, and the behaviour is otherwise identical.

## Test plan
- Reset, then load 0x0000_0025 with memory returning a line whose word 5 = 0xDEAD_BEEF → mem read at 0x20, resp_rdata 0xDEAD_BEEF in cycle 3. A repeat load hits with resp in cycle 1.
- Store 0x1234_5678 to 0x25, then load 0x4025 (same index, different tag) → write-back at 0x20 with word 5 = 0x1234_5678, then refill at 0x4020.
- Memory holds mem_req_ready low for 3 cycles during REFILL_REQ → mem_req_addr and mem_req_valid stable, resp delayed exactly 3 cycles.
- Store miss to 0x30 → refill, word 0 merged, resp_rdata = store data. A later eviction writes back the merged line.
- rst pulsed while in REFILL_WAIT, then stale mem_resp_valid → ignored, req_ready = 1, next load to the same address misses.
- With DCACHE_STATS_EN: the sequence in scenario 2 plus one hit → hit 1, miss 2, wb 1.
